fft_frame_feeder: RTL and testbench

AXI-Stream master that drives the input side of k_fixedfft. Accepts real samples on a simple valid/ready write port and buffers one full frame of 2**STAGE_NO samples. Once the frame is complete, it issues one config word on the config channel. It then streams the frame into the FFT's s_axis_data interface in order, asserting tlast on the final sample. It replaces bench-driven stimulus with a synthesizable source.

---
 rtl/fft_feeder_pkg.sv | 22 ++
 rtl/fft_feeder_ram.sv | 38 +++
 rtl/fft_frame_feeder.sv | 155 +++++++++++++++
 tb/tb_fft_frame_feeder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feeder_pkg.sv
// Shared types, default geometry and config-word packing for the FFT frame feeder.
package fft_feeder_pkg;

  localparam int unsigned DEF_STAGE_NO = 10;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned FRAME_LEN    = 2**DEF_STAGE_NO;
  localparam int unsigned ADDR_W       = DEF_STAGE_NO;
  localparam int unsigned CFG_W        = 2*DEF_STAGE_NO+1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  // Config word layout expected by k_fixedfft: scaling schedule above the direction bit.
  function automatic logic [CFG_W-1:0] make_cfg(input logic [2*DEF_STAGE_NO-1:0] scale_sch,
                                                input logic                      fwd_inv);
    return {scale_sch, fwd_inv};
  endfunction

endpackage

// File: rtl/fft_feeder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port with enable.
module fft_feeder_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register only reloads on rd_en, so it doubles as the held output beat.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Read data register; reset clears the visible output, not the contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers one frame of samples, emits one FFT config word, then streams the frame out on AXIS.
module fft_frame_feeder #(
  parameter int unsigned STAGE_NO = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CFG_W    = 2*STAGE_NO+1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [2*STAGE_NO-1:0] cfg_scale_sch,
  input  logic                  cfg_fwd_inv,
  output logic [CFG_W-1:0]      m_axis_config_tdata,
  output logic                  m_axis_config_tvalid,
  input  logic                  m_axis_config_tready,
  output logic [DATA_W-1:0]     m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  event_tlast_unexpected,
  output logic                  event_tlast_missing
);

  import fft_feeder_pkg::*;

  feeder_state_t       state_q, state_d;
  logic [STAGE_NO-1:0] wr_ptr_q, wr_ptr_d;
  logic [STAGE_NO:0]   rd_ptr_q, rd_ptr_d;   // MSB set once every address has been issued
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [15:0]         fc_q, fc_d;
  logic                ev_unexp_q, ev_unexp_d;
  logic                ev_miss_q, ev_miss_d;

  logic wr_fire, frame_done, cfg_fire, data_fire, last_fire, rd_en;

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    wr_fire    = in_valid && (state_q == FILL);
    frame_done = wr_fire && (wr_ptr_q == '1);
    cfg_fire   = (state_q == CONFIG) && m_axis_config_tready;
    data_fire  = tvalid_q && m_axis_data_tready;
    last_fire  = data_fire && tlast_q;
    // Fetch the next address whenever the output register is empty or being drained.
    rd_en      = (state_q == STREAM) && !rd_ptr_q[STAGE_NO] && (!tvalid_q || m_axis_data_tready);
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= FILL;
    else          state_q <= state_d;
  end

  // Next-state logic: FILL -> CONFIG -> STREAM -> FILL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (frame_done) state_d = CONFIG;
      CONFIG:  if (cfg_fire)   state_d = STREAM;
      STREAM:  if (last_fire)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready             = (state_q == FILL);
    m_axis_config_tvalid = (state_q == CONFIG);
    busy                 = (state_q == CONFIG) || (state_q == STREAM);
  end

  // Datapath next values: pointers, latched config, output beat flags, counters, events.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cfg_d      = cfg_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    fc_d       = fc_q;
    ev_unexp_d = 1'b0;
    ev_miss_d  = 1'b0;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == '1) begin
        cfg_d     = make_cfg(cfg_scale_sch, cfg_fwd_inv);
        ev_miss_d = !in_last;
      end else begin
        ev_unexp_d = in_last;
      end
    end
    if (data_fire) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (rd_en) begin
      tvalid_d = 1'b1;
      tlast_d  = (rd_ptr_q[STAGE_NO-1:0] == '1);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (last_fire) begin
      fc_d     = fc_q + 16'd1;
      rd_ptr_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cfg_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      fc_q       <= '0;
      ev_unexp_q <= 1'b0;
      ev_miss_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cfg_q      <= cfg_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      fc_q       <= fc_d;
      ev_unexp_q <= ev_unexp_d;
      ev_miss_q  <= ev_miss_d;
    end
  end

  fft_feeder_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (STAGE_NO)
  ) u_ram (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[STAGE_NO-1:0]),
    .rd_data (m_axis_data_tdata)
  );

  assign m_axis_config_tdata    = cfg_q;
  assign m_axis_data_tvalid     = tvalid_q;
  assign m_axis_data_tlast      = tlast_q;
  assign frame_count            = fc_q;
  assign event_tlast_unexpected = ev_unexp_q;
  assign event_tlast_missing    = ev_miss_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: frames in must come out unchanged, with one config word first.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

  localparam int STAGE_NO = 10;
  localparam int DATA_W   = 16;
  localparam int CFG_W    = 2*STAGE_NO+1;
  localparam int FLEN     = 2**STAGE_NO;

  typedef logic [DATA_W-1:0] frame_t [FLEN];
  typedef bit                flags_t [FLEN];

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic [2*STAGE_NO-1:0] cfg_scale_sch = '0;
  logic                  cfg_fwd_inv = 1'b0;
  logic [CFG_W-1:0]      m_axis_config_tdata;
  logic                  m_axis_config_tvalid;
  logic                  m_axis_config_tready = 1'b1;
  logic [DATA_W-1:0]     m_axis_data_tdata;
  logic                  m_axis_data_tvalid;
  logic                  m_axis_data_tready = 1'b1;
  logic                  m_axis_data_tlast;
  logic                  busy;
  logic [15:0]           frame_count;
  logic                  event_tlast_unexpected;
  logic                  event_tlast_missing;

  fft_frame_feeder #(.STAGE_NO(STAGE_NO), .DATA_W(DATA_W), .CFG_W(CFG_W)) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_last                (in_last),
    .in_ready               (in_ready),
    .cfg_scale_sch          (cfg_scale_sch),
    .cfg_fwd_inv            (cfg_fwd_inv),
    .m_axis_config_tdata    (m_axis_config_tdata),
    .m_axis_config_tvalid   (m_axis_config_tvalid),
    .m_axis_config_tready   (m_axis_config_tready),
    .m_axis_data_tdata      (m_axis_data_tdata),
    .m_axis_data_tvalid     (m_axis_data_tvalid),
    .m_axis_data_tready     (m_axis_data_tready),
    .m_axis_data_tlast      (m_axis_data_tlast),
    .busy                   (busy),
    .frame_count            (frame_count),
    .event_tlast_unexpected (event_tlast_unexpected),
    .event_tlast_missing    (event_tlast_missing)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running cycle index and event pulse bookkeeping.
  int cyc = 0, n_unexp = 0, n_miss = 0, miss_cyc = -1;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) begin
    if (event_tlast_unexpected === 1'b1) n_unexp <= n_unexp + 1;
    if (event_tlast_missing === 1'b1) begin
      n_miss   <= n_miss + 1;
      miss_cyc <= cyc;
    end
  end

  // Observations gathered by the driver / collector for the test tasks to judge.
  int d_timeout, d_write_cyc;
  logic [DATA_W-1:0] got [$];
  logic [CFG_W-1:0]  r_cfg_word;
  int r_timeout, r_cfg_cycles, r_cfg_drop, r_cfg_extra, r_early, r_lat;
  int r_tlast_err, r_stall_err, r_busy_err, r_post_bad;

  // Producer: writes one frame, advancing only on cycles where in_ready is seen high.
  task automatic drive_frame(input frame_t d, input flags_t lf, input logic [2*STAGE_NO-1:0] sch,
                             input logic fwd, input int gap_pct, input bit keep_valid);
    int i = 0;
    int budget = 0;
    d_timeout = 0;
    while (i < FLEN) begin
      @(negedge aclk);
      budget++;
      if (budget > 20000) begin d_timeout = 1; break; end
      cfg_scale_sch = sch;
      cfg_fwd_inv   = fwd;
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d[i];
        in_last  = lf[i];
        if (in_ready === 1'b1) begin
          if (i == FLEN-1) d_write_cyc = cyc + 1;
          i++;
        end
      end
    end
    if (!keep_valid) begin
      @(negedge aclk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cfg_scale_sch = DATA_W'($urandom) ^ 20'hFFFFF;
      cfg_fwd_inv   = ~fwd;
    end
  endtask

  // Consumer: takes the config word (after an optional stall) then one frame under random tready.
  task automatic collect_frame(input int ready_pct, input int cfg_stall);
    int budget = 0, since = 0;
    bit hs = 0, seen = 0, first = 1, done = 0, pend = 0, rdy;
    logic [DATA_W-1:0] pd;
    logic pl;
    got.delete();
    r_timeout = 0; r_cfg_cycles = 0; r_cfg_drop = 0; r_cfg_extra = 0; r_early = 0; r_lat = -1;
    r_tlast_err = 0; r_stall_err = 0; r_busy_err = 0; r_post_bad = 0; r_cfg_word = '0;
    m_axis_config_tready = (cfg_stall == 0);
    while (!hs) begin
      @(negedge aclk);
      budget++;
      if (budget > 20000) begin r_timeout = 1; return; end
      if (m_axis_data_tvalid !== 1'b0) r_early++;
      if (m_axis_config_tvalid === 1'b1) begin
        seen = 1;
        r_cfg_cycles++;
        if (in_ready !== 1'b0 || busy !== 1'b1) r_busy_err++;
        if (r_cfg_cycles > 1 && m_axis_config_tdata !== r_cfg_word) r_cfg_drop++;
        r_cfg_word = m_axis_config_tdata;
        if (r_cfg_cycles > cfg_stall) begin m_axis_config_tready = 1'b1; hs = 1; end
        else m_axis_config_tready = 1'b0;
      end else if (seen) begin
        r_cfg_drop++;
      end
    end
    while (!done) begin
      @(negedge aclk);
      budget++;
      if (budget > 20000) begin r_timeout = 1; return; end
      since++;
      if (m_axis_config_tvalid !== 1'b0) r_cfg_extra++;
      if (in_ready !== 1'b0 || busy !== 1'b1) r_busy_err++;
      if (pend && (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== pd || m_axis_data_tlast !== pl))
        r_stall_err++;
      if (m_axis_data_tvalid === 1'b1 && first) begin r_lat = since; first = 0; end
      rdy = (int'($urandom_range(99)) < ready_pct);
      m_axis_data_tready = rdy;
      pend = (m_axis_data_tvalid === 1'b1) && !rdy;
      pd = m_axis_data_tdata;
      pl = m_axis_data_tlast;
      if (m_axis_data_tvalid === 1'b1 && rdy) begin
        got.push_back(m_axis_data_tdata);
        if (m_axis_data_tlast === 1'b1) begin
          if (got.size() != FLEN) r_tlast_err++;
          done = 1;
        end else if (got.size() >= FLEN + 4) begin
          r_tlast_err++;
          done = 1;
        end
      end
    end
    @(negedge aclk);
    if (in_ready !== 1'b1 || busy !== 1'b0 || m_axis_data_tvalid !== 1'b0 ||
        m_axis_data_tlast !== 1'b0 || m_axis_config_tvalid !== 1'b0) r_post_bad = 1;
    m_axis_data_tready = 1'b1;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    m_axis_config_tready = 1'b1; m_axis_data_tready = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  function automatic void rand_frame(output frame_t f);
    for (int i = 0; i < FLEN; i++) f[i] = DATA_W'($urandom);
  endfunction

  function automatic int count_diff(input frame_t exp);
    int e = 0;
    for (int i = 0; i < FLEN; i++) if (i >= got.size() || got[i] !== exp[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if ({m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast, busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast, busy}); end
    n_checks++; if ({m_axis_config_tdata, m_axis_data_tdata, frame_count} !== '0) begin
      n_fail++; $display("FAIL reset_data cfg=%h data=%h fc=%0d exp=0", m_axis_config_tdata, m_axis_data_tdata, frame_count); end
    n_checks++; if ({event_tlast_unexpected, event_tlast_missing} !== 2'b0) begin
      n_fail++; $display("FAIL reset_events got=%b exp=00", {event_tlast_unexpected, event_tlast_missing}); end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release in_ready=%b busy=%b exp=1/0", in_ready, busy); end
  endtask

  task automatic test_config_path();
    frame_t s; flags_t lf; int u0, m0, e;
    apply_reset();
    for (int i = 0; i < FLEN; i++) begin
      s[i] = DATA_W'($rtoi(32767.0 * $sin(6.283185307179586 * i / 1024.0)));
      lf[i] = (i == FLEN-1);
    end
    u0 = n_unexp; m0 = n_miss;
    fork
      drive_frame(s, lf, {10{2'b01}}, 1'b1, 0, 0);
      collect_frame(100, 0);
    join
    e = count_diff(s);
    n_checks++; if (r_timeout || d_timeout) begin n_fail++; $display("FAIL cfgpath_timeout got=%0d/%0d exp=0/0", r_timeout, d_timeout); end
    n_checks++; if (r_cfg_word !== 21'h0AAAAB) begin n_fail++; $display("FAIL cfgpath_word got=%h exp=0aaaab", r_cfg_word); end
    n_checks++; if (r_cfg_cycles != 1) begin n_fail++; $display("FAIL cfgpath_cfg_cycles got=%0d exp=1", r_cfg_cycles); end
    n_checks++; if (got.size() != FLEN || e != 0) begin n_fail++; $display("FAIL cfgpath_data beats=%0d bad=%0d exp=%0d/0", got.size(), e, FLEN); end
    n_checks++; if (r_tlast_err != 0) begin n_fail++; $display("FAIL cfgpath_tlast errs=%0d exp=0", r_tlast_err); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL cfgpath_frame_count got=%0d exp=1", frame_count); end
    n_checks++; if (n_unexp != u0 || n_miss != m0) begin n_fail++; $display("FAIL cfgpath_events unexp=%0d miss=%0d exp=0/0", n_unexp-u0, n_miss-m0); end
    n_checks++; if (r_lat != 2 || r_post_bad != 0 || r_busy_err != 0 || r_cfg_extra != 0) begin
      n_fail++; $display("FAIL cfgpath_timing lat=%0d post=%0d busyerr=%0d cfgextra=%0d exp=2/0/0/0", r_lat, r_post_bad, r_busy_err, r_cfg_extra); end
  endtask

  task automatic test_backpressure();
    frame_t s; flags_t lf; int e; logic [19:0] sch;
    apply_reset();
    for (int i = 0; i < FLEN; i++) begin
      s[i] = DATA_W'($rtoi(32767.0 * $sin(6.283185307179586 * i / 1024.0)));
      lf[i] = (i == FLEN-1);
    end
    sch = 20'($urandom);
    fork
      drive_frame(s, lf, sch, 1'b0, 0, 0);
      collect_frame(50, 0);
    join
    e = count_diff(s);
    n_checks++; if (r_timeout || d_timeout) begin n_fail++; $display("FAIL bp_timeout got=%0d/%0d exp=0/0", r_timeout, d_timeout); end
    n_checks++; if (r_stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable errs=%0d exp=0", r_stall_err); end
    n_checks++; if (got.size() != FLEN || e != 0) begin n_fail++; $display("FAIL bp_data beats=%0d bad=%0d exp=%0d/0", got.size(), e, FLEN); end
    n_checks++; if (r_tlast_err != 0 || frame_count !== 16'd1) begin n_fail++; $display("FAIL bp_tlast_fc errs=%0d fc=%0d exp=0/1", r_tlast_err, frame_count); end
    n_checks++; if (r_cfg_word !== {sch, 1'b0}) begin n_fail++; $display("FAIL bp_cfg_word got=%h exp=%h", r_cfg_word, {sch, 1'b0}); end
  endtask

  task automatic test_framing_errors();
    frame_t s; flags_t lf; int u0, m0, e; logic [19:0] sch;
    apply_reset();
    rand_frame(s);
    for (int i = 0; i < FLEN; i++) lf[i] = (i == 100) || (i == FLEN-1);
    sch = 20'($urandom);
    u0 = n_unexp; m0 = n_miss;
    fork
      drive_frame(s, lf, sch, 1'b1, 25, 0);
      collect_frame(80, 0);
    join
    e = count_diff(s);
    n_checks++; if (n_unexp - u0 != 1 || n_miss != m0) begin n_fail++; $display("FAIL early_last_events unexp=%0d miss=%0d exp=1/0", n_unexp-u0, n_miss-m0); end
    n_checks++; if (got.size() != FLEN || e != 0 || r_tlast_err != 0) begin
      n_fail++; $display("FAIL early_last_frame beats=%0d bad=%0d tlasterr=%0d exp=%0d/0/0", got.size(), e, r_tlast_err, FLEN); end
    rand_frame(s);
    for (int i = 0; i < FLEN; i++) lf[i] = 0;
    u0 = n_unexp; m0 = n_miss;
    fork
      drive_frame(s, lf, sch, 1'b0, 0, 0);
      collect_frame(100, 0);
    join
    e = count_diff(s);
    n_checks++; if (n_miss - m0 != 1 || n_unexp != u0) begin n_fail++; $display("FAIL no_last_events miss=%0d unexp=%0d exp=1/0", n_miss-m0, n_unexp-u0); end
    n_checks++; if (miss_cyc != d_write_cyc) begin n_fail++; $display("FAIL no_last_pulse_cycle got=%0d exp=%0d", miss_cyc, d_write_cyc); end
    n_checks++; if (got.size() != FLEN || e != 0 || frame_count !== 16'd2) begin
      n_fail++; $display("FAIL no_last_frame beats=%0d bad=%0d fc=%0d exp=%0d/0/2", got.size(), e, frame_count, FLEN); end
  endtask

  task automatic test_config_stall();
    frame_t s; flags_t lf; int e; logic [19:0] sch; logic fwd;
    apply_reset();
    rand_frame(s);
    for (int i = 0; i < FLEN; i++) lf[i] = (i == FLEN-1);
    sch = 20'($urandom); fwd = 1'($urandom);
    fork
      drive_frame(s, lf, sch, fwd, 0, 0);
      collect_frame(100, 50);
    join
    e = count_diff(s);
    n_checks++; if (r_cfg_cycles != 51 || r_cfg_drop != 0) begin n_fail++; $display("FAIL stall_cfg_hold cycles=%0d drops=%0d exp=51/0", r_cfg_cycles, r_cfg_drop); end
    n_checks++; if (r_early != 0) begin n_fail++; $display("FAIL stall_early_data got=%0d exp=0", r_early); end
    n_checks++; if (r_lat != 2) begin n_fail++; $display("FAIL stall_first_latency got=%0d exp=2", r_lat); end
    n_checks++; if (r_cfg_word !== {sch, fwd}) begin n_fail++; $display("FAIL stall_cfg_word got=%h exp=%h", r_cfg_word, {sch, fwd}); end
    n_checks++; if (got.size() != FLEN || e != 0) begin n_fail++; $display("FAIL stall_data beats=%0d bad=%0d exp=%0d/0", got.size(), e, FLEN); end
  endtask

  task automatic test_reset_mid_stream();
    frame_t s; flags_t lf; int beats = 0, budget = 0, e;
    apply_reset();
    rand_frame(s);
    for (int i = 0; i < FLEN; i++) lf[i] = (i == FLEN-1);
    drive_frame(s, lf, 20'h12345, 1'b1, 0, 0);
    while (beats < 500 && budget < 5000) begin
      @(negedge aclk);
      budget++;
      if (m_axis_data_tvalid === 1'b1) beats++;
    end
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    n_checks++; if (beats != 500) begin n_fail++; $display("FAIL midrst_reach_beat got=%0d exp=500", beats); end
    n_checks++; if (in_ready !== 1'b1 || {m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast, busy} !== 4'b0) begin
      n_fail++; $display("FAIL midrst_async_flags in_ready=%b flags=%b exp=1/0000", in_ready,
                         {m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast, busy}); end
    n_checks++; if ({m_axis_config_tdata, m_axis_data_tdata, frame_count} !== '0) begin
      n_fail++; $display("FAIL midrst_async_data cfg=%h data=%h fc=%0d exp=0", m_axis_config_tdata, m_axis_data_tdata, frame_count); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready got=%b exp=1", in_ready); end
    rand_frame(s);
    fork
      drive_frame(s, lf, 20'h0F0F0, 1'b0, 0, 0);
      collect_frame(100, 0);
    join
    e = count_diff(s);
    n_checks++; if (got.size() != FLEN || e != 0 || frame_count !== 16'd1) begin
      n_fail++; $display("FAIL midrst_fresh_frame beats=%0d bad=%0d fc=%0d exp=%0d/0/1", got.size(), e, frame_count, FLEN); end
  endtask

  task automatic test_back_to_back();
    frame_t f0, f1, f2; flags_t lf; logic [19:0] sch [3];
    int e [3], sz [3], be [3], pb [3]; logic [CFG_W-1:0] cw [3];
    apply_reset();
    rand_frame(f0); rand_frame(f1); rand_frame(f2);
    for (int i = 0; i < FLEN; i++) lf[i] = (i == FLEN-1);
    for (int k = 0; k < 3; k++) sch[k] = 20'($urandom);
    fork
      begin
        drive_frame(f0, lf, sch[0], 1'b1, 0, 1);
        drive_frame(f1, lf, sch[1], 1'b0, 0, 1);
        drive_frame(f2, lf, sch[2], 1'b1, 0, 0);
      end
      begin
        collect_frame(70, 0);  e[0] = count_diff(f0); sz[0] = got.size(); be[0] = r_busy_err; pb[0] = r_post_bad; cw[0] = r_cfg_word;
        collect_frame(100, 0); e[1] = count_diff(f1); sz[1] = got.size(); be[1] = r_busy_err; pb[1] = r_post_bad; cw[1] = r_cfg_word;
        collect_frame(60, 3);  e[2] = count_diff(f2); sz[2] = got.size(); be[2] = r_busy_err; pb[2] = r_post_bad; cw[2] = r_cfg_word;
      end
    join
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (sz[k] != FLEN || e[k] != 0) begin n_fail++; $display("FAIL b2b_data frame=%0d beats=%0d bad=%0d exp=%0d/0", k, sz[k], e[k], FLEN); end
      n_checks++; if (be[k] != 0 || pb[k] != 0) begin n_fail++; $display("FAIL b2b_in_ready frame=%0d busyerr=%0d post=%0d exp=0/0", k, be[k], pb[k]); end
      n_checks++; if (cw[k] !== {sch[k], (k != 1) ? 1'b1 : 1'b0}) begin
        n_fail++; $display("FAIL b2b_cfg_word frame=%0d got=%h exp=%h", k, cw[k], {sch[k], (k != 1) ? 1'b1 : 1'b0}); end
    end
    n_checks++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL b2b_frame_count got=%0d exp=3", frame_count); end
  endtask

  initial begin
    test_reset();
    test_config_path();
    test_backpressure();
    test_framing_errors();
    test_config_stall();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
